// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared ASCII constants and console state encoding
package console_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_X  = 8'h78;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int CONSOLE_STATE_W = 3;

    typedef enum logic [CONSOLE_STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_PREFIX0 = 3'd1,
        ST_PREFIXX = 3'd2,
        ST_DIGITS  = 3'd3,
        ST_CR      = 3'd4,
        ST_LF      = 3'd5
    } console_state_t;

endpackage

// File: rtl/hexdigit.sv
// rtl/hexdigit.sv - nibble to lowercase ASCII hex digit
module hexdigit (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = 8'h57 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/hex_word_streamer.sv
// rtl/hex_word_streamer.sv - streams a latched word as framed ASCII hex characters
module hex_word_streamer
    import console_pkg::*;
#(
    parameter int NIBBLES        = 8,
    parameter int PREFIX_0X      = 1,
    parameter int EMIT_CRLF      = 1,
    parameter int SUPPRESS_ZEROS = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [4*NIBBLES-1:0] in_word,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           out_char,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] IDX_ONE = IW'(1);
    localparam logic [IW-1:0] IDX_TOP = IW'(NIBBLES - 1);

    console_state_t state_q, state_d;
    logic [W-1:0]   word_q;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  start_idx;
    logic [7:0]     char_d;
    logic           valid_d;
    logic [3:0]     conv_nibble;
    logic [7:0]     conv_ascii;
    logic           accept;
    logic           handshake;

    // Highest non-zero nibble wins; a zero word falls back to index 0.
    function automatic logic [IW-1:0] first_idx(input logic [W-1:0] w);
        logic [IW-1:0] r;
        r = IDX_TOP;
        if (SUPPRESS_ZEROS != 0) begin
            r = '0;
            for (int i = 0; i < NIBBLES; i++) begin
                if (w[4*i +: 4] != 4'h0) begin
                    r = IW'(i);
                end
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] nibble_at(input logic [W-1:0] w, input logic [IW-1:0] idx);
        logic [3:0] n;
        n = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (IW'(i) == idx) begin
                n = w[4*i +: 4];
            end
        end
        return n;
    endfunction

    assign in_ready  = (state_q == ST_IDLE) && !reset;
    assign busy      = (state_q != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign start_idx = first_idx(in_word);

    // The converter always looks at the digit that will be loaded next.
    always_comb begin
        case (state_q)
            ST_IDLE:   conv_nibble = nibble_at(in_word, start_idx);
            ST_DIGITS: conv_nibble = nibble_at(word_q, idx_q - IDX_ONE);
            default:   conv_nibble = nibble_at(word_q, idx_q);
        endcase
    end

    hexdigit u_hexdigit (
        .nibble (conv_nibble),
        .ascii  (conv_ascii)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        char_d  = out_char;
        valid_d = out_valid;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    idx_d   = start_idx;
                    valid_d = 1'b1;
                    if (PREFIX_0X != 0) begin
                        state_d = ST_PREFIX0;
                        char_d  = ASCII_0;
                    end else begin
                        state_d = ST_DIGITS;
                        char_d  = conv_ascii;
                    end
                end
            end
            ST_PREFIX0: begin
                if (handshake) begin
                    state_d = ST_PREFIXX;
                    char_d  = ASCII_X;
                end
            end
            ST_PREFIXX: begin
                if (handshake) begin
                    state_d = ST_DIGITS;
                    char_d  = conv_ascii;
                end
            end
            ST_DIGITS: begin
                if (handshake) begin
                    if (idx_q != '0) begin
                        idx_d  = idx_q - IDX_ONE;
                        char_d = conv_ascii;
                    end else if (EMIT_CRLF != 0) begin
                        state_d = ST_CR;
                        char_d  = ASCII_CR;
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            ST_CR: begin
                if (handshake) begin
                    state_d = ST_LF;
                    char_d  = ASCII_LF;
                end
            end
            ST_LF: begin
                if (handshake) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            idx_q     <= '0;
            out_char  <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            out_char  <= char_d;
            out_valid <= valid_d;
            if (accept) begin
                word_q <= in_word;
            end
        end
    end

endmodule

// File: tb/tb_hex_word_streamer.sv
// tb/tb_hex_word_streamer.sv - scoreboard bench for three streamer configurations
module tb_hex_word_streamer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] w0, w1;
    logic [3:0]  w2;
    logic [2:0]  iv, ir, ov, ordy, bz;
    logic [7:0]  oc [3];

    int total = 0;
    int bad   = 0;
    int cur   = 0;
    int mode  = 0;
    int bp_cnt = 0;
    logic [7:0] exp_q[$];
    logic [2:0] hold_pend;
    logic [7:0] hold_char [3];

    int nib_c  [3] = '{8, 8, 1};
    bit pre_c  [3] = '{1'b1, 1'b0, 1'b1};
    bit crlf_c [3] = '{1'b1, 1'b0, 1'b1};
    bit sz_c   [3] = '{1'b0, 1'b1, 1'b0};

    always #5 clock = ~clock;

    hex_word_streamer u_def (
        .clock(clock), .reset(reset), .in_word(w0), .in_valid(iv[0]), .in_ready(ir[0]),
        .out_char(oc[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .busy(bz[0])
    );

    hex_word_streamer #(.NIBBLES(8), .PREFIX_0X(0), .EMIT_CRLF(0), .SUPPRESS_ZEROS(1)) u_sz (
        .clock(clock), .reset(reset), .in_word(w1), .in_valid(iv[1]), .in_ready(ir[1]),
        .out_char(oc[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .busy(bz[1])
    );

    hex_word_streamer #(.NIBBLES(1)) u_n1 (
        .clock(clock), .reset(reset), .in_word(w2), .in_valid(iv[2]), .in_ready(ir[2]),
        .out_char(oc[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .busy(bz[2])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference: render the word as text, then frame it.
    task automatic push_expected(input int k, input logic [31:0] w);
        int top;
        logic [3:0] d;
        if (pre_c[k]) begin
            exp_q.push_back(8'h30);
            exp_q.push_back(8'h78);
        end
        top = nib_c[k] - 1;
        if (sz_c[k]) begin
            top = 0;
            for (int i = nib_c[k] - 1; i >= 0; i--) begin
                if (((w >> (4 * i)) & 32'hF) != 0) begin
                    top = i;
                    break;
                end
            end
        end
        for (int i = top; i >= 0; i--) begin
            d = 4'((w >> (4 * i)) & 32'hF);
            exp_q.push_back((d < 4'd10) ? (8'h30 + 8'(d)) : (8'h57 + 8'(d)));
        end
        if (crlf_c[k]) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic send(input int k, input logic [31:0] w);
        int n;
        cur = k;
        push_expected(k, w);
        n = 0;
        while (!ir[k] && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
        if (!ir[k]) check("in_ready_timeout", 64'(ir[k]), 64'd1);
        case (k)
            0: w0 = w;
            1: w1 = w;
            default: w2 = w[3:0];
        endcase
        iv[k] = 1'b1;
        @(posedge clock); #1;
        iv[k] = 1'b0;
        check("accept_busy", 64'(bz[k]), 64'd1);
        check("accept_in_ready_low", 64'(ir[k]), 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bz[cur]) && n < 2000) begin
            @(posedge clock); #1;
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        ordy = '1;
        forever begin
            @(posedge clock); #1;
            bp_cnt++;
            case (mode)
                0: ordy = '1;
                1: ordy = {3{(bp_cnt % 4 == 0) || (bp_cnt % 4 == 3)}};
                default: ordy = 3'($urandom);
            endcase
        end
    end

    initial begin
        logic [7:0] e;
        hold_pend = '0;
        forever begin
            @(negedge clock);
            for (int k = 0; k < 3; k++) begin
                if (reset) begin
                    hold_pend[k] = 1'b0;
                end else begin
                    if (hold_pend[k]) begin
                        check("hold_stable", {55'd0, ov[k], oc[k]}, {55'd0, 1'b1, hold_char[k]});
                    end
                    if (ov[k] && ordy[k]) begin
                        if (k != cur || exp_q.size() == 0) begin
                            check("unexpected_char", {48'd0, 8'(k), oc[k]}, 64'hFFFF);
                        end else begin
                            e = exp_q.pop_front();
                            check("char", 64'(oc[k]), 64'(e));
                        end
                    end
                    hold_pend[k] = ov[k] && !ordy[k];
                    hold_char[k] = oc[k];
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        reset = 1'b1;
        iv = '0;
        w0 = '0;
        w1 = '0;
        w2 = '0;
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_out_valid", 64'(ov[k]), 64'd0);
            check("rst_busy", 64'(bz[k]), 64'd0);
            check("rst_in_ready", 64'(ir[k]), 64'd0);
            check("rst_out_char", 64'(oc[k]), 64'd0);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_in_ready", 64'(ir[0]), 64'd1);

        // Exact timing: 12 back-to-back characters, then in_ready.
        send(0, 32'hDEADBEEF);
        for (int j = 0; j < 12; j++) begin
            @(negedge clock);
            check("burst_valid", 64'(ov[0]), 64'd1);
        end
        @(negedge clock);
        check("done_valid_low", 64'(ov[0]), 64'd0);
        check("done_in_ready", 64'(ir[0]), 64'd1);
        drain();

        mode = 1;
        send(0, 32'hDEADBEEF);
        drain();
        mode = 0;

        send(1, 32'h000000A5); drain();
        send(1, 32'h00000000); drain();
        send(1, 32'h80000000); drain();

        // in_valid while busy must be ignored.
        send(0, 32'hCAFEF00D);
        repeat (3) @(posedge clock);
        #1;
        w0 = 32'h12345678;
        iv[0] = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        iv[0] = 1'b0;
        drain();
        send(0, 32'h12345678);
        drain();

        // Reset in the middle of the digits.
        send(0, 32'hDEADBEEF);
        repeat (3) @(posedge clock);
        #1;
        exp_q.delete();
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(ov[0]), 64'd0);
        check("midrst_busy", 64'(bz[0]), 64'd0);
        check("midrst_in_ready", 64'(ir[0]), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        send(0, 32'h00000001);
        drain();

        send(2, 32'h0000000F);
        drain();

        for (int r = 0; r < 60; r++) begin
            int k;
            k = r % 3;
            mode = int'($urandom_range(0, 2));
            w = $urandom;
            if (k == 1) w = w >> $urandom_range(0, 32);
            if (k == 2) w = w & 32'hF;
            send(k, w);
            drain();
        end
        mode = 0;
        repeat (4) @(posedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
